// File: rtl/fifo_stream_serializer.sv
// fifo_stream_serializer
//
// Pops WIDTH-bit words from a synchronous FIFO (registered data_out and
// registered empty flag) and emits each one as R = WIDTH/OUT_WIDTH chunks of
// OUT_WIDTH bits on a valid/ready stream. m_last marks the final chunk of
// each word. WIDTH must be an integer multiple of OUT_WIDTH.
//
// The FIFO's one-cycle read latency is absorbed by a WAIT state. No read is
// issued while another read is in flight, so fifo_empty has always caught up
// with the previous pop by the time it is sampled.
//
// Optional build macro:
//   SERIALIZER_PREFETCH_EN - when defined, the last-chunk handshake issues the
//   next FIFO read in the same cycle if the FIFO is non-empty. This removes one
//   bubble between words: R+1 cycles per word instead of R+2.
//
// Parameters:
//   WIDTH      FIFO word width
//   OUT_WIDTH  output chunk width
//   MSB_FIRST  1: chunk 0 is the most-significant slice; 0: least-significant
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after an accepted read
//   fifo_rd     FIFO read strobe
//   m_valid     chunk valid
//   m_ready     downstream accepts chunk
//   m_data      chunk payload
//   m_last      high with the final chunk of a word
//   busy        high whenever the serializer is not idle
module fifo_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_rd,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int R  = WIDTH / OUT_WIDTH;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(R - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic [OUT_WIDTH-1:0] chunks [R];
  logic [OUT_WIDTH-1:0] chunk_sel;
  logic                 handshake;
  logic                 at_last;

  // Slice the held word into chunks in emission order, so chunk index k is
  // simply the k-th chunk sent regardless of MSB_FIRST.
  for (genvar g = 0; g < R; g++) begin : g_chunk
    if (MSB_FIRST) begin : g_msb
      assign chunks[g] = word_q[WIDTH-1-g*OUT_WIDTH -: OUT_WIDTH];
    end else begin : g_lsb
      assign chunks[g] = word_q[g*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // Compare-based mux keeps the select width-safe when R = 1.
  always_comb begin
    chunk_sel = '0;
    for (int k = 0; k < R; k++) begin
      if (cnt_q == CW'(k)) begin
        chunk_sel = chunks[k];
      end
    end
  end

  // Stream outputs depend only on registered state, never on m_ready, so they
  // hold steady through any stall.
  assign m_valid   = (state_q == SHIFT);
  assign at_last   = (cnt_q == LAST_IDX);
  assign handshake = m_valid & m_ready;
  assign m_data    = m_valid ? chunk_sel : '0;
  assign m_last    = m_valid & at_last;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    fifo_rd = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        word_d  = fifo_data;
        cnt_d   = '0;
        state_d = SHIFT;
      end

      SHIFT: begin
        if (handshake) begin
          if (at_last) begin
`ifdef SERIALIZER_PREFETCH_EN
            // The previous read was at least two cycles ago (IDLE/SHIFT ->
            // WAIT -> SHIFT), so fifo_empty is settled and a read is legal.
            if (!fifo_empty) begin
              fifo_rd = 1'b1;
              state_d = WAIT;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A word popped during reset would be lost, so never read while in reset.
    if (rst) begin
      fifo_rd = 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_stream_serializer.sv
// tb_fifo_stream_serializer
//
// Three serializer instances share clk/rst:
//   lane 0: WIDTH=8 OUT_WIDTH=4 MSB_FIRST=1
//   lane 1: WIDTH=8 OUT_WIDTH=4 MSB_FIRST=0
//   lane 2: WIDTH=8 OUT_WIDTH=8 (single chunk per word)
// Each lane has a registered-output FIFO model. Every word the FIFO hands out
// is queued as expected; the compare process derives each expected chunk
// from that word by plain shift/mask arithmetic.
module tb_fifo_stream_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fifo_empty = 3'b111;
  logic [7:0] fifo_data [3] = '{default: 8'h00};
  logic [2:0] fifo_rd;
  logic [2:0] m_valid;
  logic [2:0] m_last;
  logic [2:0] busy;
  logic [2:0] m_ready = 3'b111;
  logic [3:0] md0;
  logic [3:0] md1;
  logic [7:0] md2;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem  [3][256];
  logic [7:0] expw [3][256];
  int wr_ptr [3];
  int rd_ptr [3];
  int exp_wr [3];
  int exp_rd [3];
  int idx    [3];
  int done   [3];

`ifdef SERIALIZER_PREFETCH_EN
  localparam int WORD_GAP = 2;
`else
  localparam int WORD_GAP = 3;
`endif

  always #5 clk = ~clk;

  fifo_stream_serializer #(.WIDTH(8), .OUT_WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_rd(fifo_rd[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(md0), .m_last(m_last[0]), .busy(busy[0])
  );

  fifo_stream_serializer #(.WIDTH(8), .OUT_WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_rd(fifo_rd[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(md1), .m_last(m_last[1]), .busy(busy[1])
  );

  fifo_stream_serializer #(.WIDTH(8), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_wide (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[2]),
    .fifo_rd(fifo_rd[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
    .m_data(md2), .m_last(m_last[2]), .busy(busy[2])
  );

  function automatic int lane_r(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int lane_ow(input int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic bit lane_msb(input int i);
    return (i != 1);
  endfunction

  function automatic int lane_data(input int i);
    case (i)
      0:       return int'(md0);
      1:       return int'(md1);
      default: return int'(md2);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Pushes one word into a lane's FIFO model.
  task automatic applyStimulus(input int lane, input logic [7:0] word);
    mem[lane][wr_ptr[lane]] = word;
    wr_ptr[lane] = wr_ptr[lane] + 1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // FIFO model: registered data_out and registered empty flag.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fifo_rd[i] && (rd_ptr[i] != wr_ptr[i])) begin
        fifo_data[i]         <= mem[i][rd_ptr[i]];
        expw[i][exp_wr[i]]   <= mem[i][rd_ptr[i]];
        exp_wr[i]            <= exp_wr[i] + 1;
        rd_ptr[i]            <= rd_ptr[i] + 1;
        fifo_empty[i]        <= ((rd_ptr[i] + 1) == wr_ptr[i]);
      end else begin
        fifo_empty[i]        <= (rd_ptr[i] == wr_ptr[i]);
      end
    end
  end

  // Compare process: checks every lane on every cycle, away from the edge.
  logic [2:0] prev_rd    = '0;
  logic [2:0] prev_stall = '0;
  int prev_data [3];
  int prev_last [3];

  always begin
    int w, r, ow, sh, ec, el, ad, al;
    @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        exp_rd[i]     = exp_wr[i];
        idx[i]        = 0;
        prev_rd[i]    = 1'b0;
        prev_stall[i] = 1'b0;
      end else begin
        ad = lane_data(i);
        al = int'(m_last[i]);
        if (fifo_rd[i]) begin
          checkOutput($sformatf("lane%0d_rd_in_flight", i), int'(prev_rd[i]), 0);
          checkOutput($sformatf("lane%0d_rd_when_empty", i), int'(fifo_empty[i]), 0);
        end
        if (prev_stall[i]) begin
          checkOutput($sformatf("lane%0d_stall_valid", i), int'(m_valid[i]), 1);
          checkOutput($sformatf("lane%0d_stall_data", i), ad, prev_data[i]);
          checkOutput($sformatf("lane%0d_stall_last", i), al, prev_last[i]);
        end
        if (m_valid[i]) begin
          checkOutput($sformatf("lane%0d_busy_with_valid", i), int'(busy[i]), 1);
          if (exp_rd[i] == exp_wr[i]) begin
            checks++;
            failures++;
            $display("[TB] FAIL lane%0d_unexpected_chunk actual=0x%0h expected=no chunk at %0t", i, ad, $time);
          end else begin
            w  = int'(expw[i][exp_rd[i]]);
            r  = lane_r(i);
            ow = lane_ow(i);
            sh = lane_msb(i) ? (r - 1 - idx[i]) * ow : idx[i] * ow;
            ec = (w >> sh) & ((1 << ow) - 1);
            el = (idx[i] == r - 1) ? 1 : 0;
            checkOutput($sformatf("lane%0d_chunk_data", i), ad, ec);
            checkOutput($sformatf("lane%0d_chunk_last", i), al, el);
            if (m_ready[i]) begin
              if (el == 1) begin
                exp_rd[i] = exp_rd[i] + 1;
                idx[i]    = 0;
                done[i]   = done[i] + 1;
              end else begin
                idx[i] = idx[i] + 1;
              end
            end
          end
        end
        prev_rd[i]    = fifo_rd[i];
        prev_stall[i] = m_valid[i] & ~m_ready[i];
        prev_data[i]  = ad;
        prev_last[i]  = al;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int found;
    int n;
    int cd [8];
    int cl [8];
    int cc [8];

    repeat (3) tick();
    rst = 1'b0;

    // Empty FIFO: nothing moves.
    for (int k = 0; k < 20; k++) begin
      tick();
      #2;
      checkOutput("idle_fifo_rd", int'(fifo_rd), 0);
      checkOutput("idle_m_valid", int'(m_valid), 0);
      checkOutput("idle_busy", int'(busy), 0);
    end

    // Single word 0xA5, MSB first: A then 5, two cycles after the read.
    applyStimulus(0, 8'hA5);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick();
      #2;
      if (fifo_rd[0]) found = 1;
    end
    checkOutput("a5_read_issued", found, 1);
    tick(); #2;
    checkOutput("a5_t1_valid", int'(m_valid[0]), 0);
    tick(); #2;
    checkOutput("a5_t2_valid", int'(m_valid[0]), 1);
    checkOutput("a5_t2_data", int'(md0), 'hA);
    checkOutput("a5_t2_last", int'(m_last[0]), 0);
    tick(); #2;
    checkOutput("a5_t3_valid", int'(m_valid[0]), 1);
    checkOutput("a5_t3_data", int'(md0), 'h5);
    checkOutput("a5_t3_last", int'(m_last[0]), 1);
    tick(); #2;
    checkOutput("a5_t4_valid", int'(m_valid[0]), 0);

    // LSB first, back-to-back words 0x3C, 0x7E: C,3,E,7.
    for (int k = 0; k < 8; k++) begin cd[k] = -1; cl[k] = -1; cc[k] = -1; end
    applyStimulus(1, 8'h3C);
    applyStimulus(1, 8'h7E);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      #2;
      if (m_valid[1] && m_ready[1] && n < 8) begin
        cd[n] = int'(md1);
        cl[n] = int'(m_last[1]);
        cc[n] = k;
        n++;
      end
    end
    checkOutput("lsb_chunk_count", n, 4);
    checkOutput("lsb_c0", cd[0], 'hC);
    checkOutput("lsb_c1", cd[1], 'h3);
    checkOutput("lsb_c2", cd[2], 'hE);
    checkOutput("lsb_c3", cd[3], 'h7);
    checkOutput("lsb_last_pattern", (cl[0] << 3) | (cl[1] << 2) | (cl[2] << 1) | cl[3], 'b0101);
    checkOutput("lsb_intra_word_spacing", cc[1] - cc[0], 1);
    checkOutput("lsb_word_spacing", cc[2] - cc[1], WORD_GAP);

    // 100 random words with ~50% random m_ready on lane 0.
    n = 0;
    for (int k = 0; k < 4000 && n < 100; k++) begin
      tick();
      m_ready[0] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        applyStimulus(0, 8'($urandom));
        n++;
      end
    end
    for (int k = 0; k < 3000; k++) begin
      tick();
      m_ready[0] = 1'($urandom_range(0, 1));
      #2;
      if (done[0] == 101 && !busy[0]) break;
    end
    checkOutput("rand_words_delivered", done[0], 101);

    // Reset while the second chunk of 0xA5 is on the bus.
    tick();
    m_ready[0] = 1'b1;
    applyStimulus(0, 8'hA5);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick();
      #2;
      if (m_valid[0] && md0 == 4'hA) found = 1;
    end
    checkOutput("rst_first_chunk_seen", found, 1);
    tick();
    rst = 1'b1;
    #2;
    checkOutput("rst_second_chunk_data", int'(md0), 'h5);
    tick();
    rst = 1'b0;
    #2;
    checkOutput("rst_after_valid", int'(m_valid[0]), 0);
    checkOutput("rst_after_busy", int'(busy[0]), 0);
    applyStimulus(0, 8'h12);
    for (int k = 0; k < 8; k++) begin cd[k] = -1; cl[k] = -1; end
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      #2;
      if (m_valid[0] && m_ready[0] && n < 8) begin
        cd[n] = int'(md0);
        cl[n] = int'(m_last[0]);
        n++;
      end
    end
    checkOutput("post_rst_count", n, 2);
    checkOutput("post_rst_c0", cd[0], 'h1);
    checkOutput("post_rst_c1", cd[1], 'h2);
    checkOutput("post_rst_last", (cl[0] << 1) | cl[1], 'b01);

    // Single-chunk lane: four words, each one transfer with m_last.
    for (int k = 0; k < 8; k++) begin cd[k] = -1; cl[k] = -1; end
    for (int k = 1; k <= 4; k++) applyStimulus(2, 8'(k));
    n = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      #2;
      if (m_valid[2] && m_ready[2] && n < 8) begin
        cd[n] = int'(md2);
        cl[n] = int'(m_last[2]);
        n++;
      end
    end
    checkOutput("wide_count", n, 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("wide_data%0d", k), cd[k], k + 1);
      checkOutput($sformatf("wide_last%0d", k), cl[k], 1);
    end

    repeat (5) tick();
    #2;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("lane%0d_pending_words", i), exp_wr[i] - exp_rd[i], 0);
      checkOutput($sformatf("lane%0d_fifo_drained", i), wr_ptr[i] - rd_ptr[i], 0);
    end
    checkOutput("lane0_words_done", done[0], 102);
    checkOutput("lane1_words_done", done[1], 2);
    checkOutput("lane2_words_done", done[2], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
